// File: rtl/vending_pkg.sv
// Shared types and defaults for the cafe/sopa vending controller.
// Optional idle auto-refund is enabled with VENDING_TIMEOUT_EN.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    typedef enum logic [1:0] {
        PROD_NONE,
        PROD_CAFE,
        PROD_SOPA
    } prod_t;

    localparam int COIN_W           = 4;
    localparam int DEF_CREDIT_W     = 8;
    localparam int DEF_PRICE_CAFE   = 3;
    localparam int DEF_PRICE_SOPA   = 5;
    localparam int DEF_MAX_CREDIT   = 20;
    localparam int DEF_DISP_CYCLES  = 4;
    localparam int DEF_TIMEOUT      = 1000;

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/vending_ctrl_if.sv
// Front-panel / coin-acceptor / actuator bundle of the vending controller.
// master = panel side, slave = controller side.
interface vending_ctrl_if #(
    parameter int CREDIT_W = 8
);
    import vending_pkg::*;

    logic              coin_valid;
    logic [COIN_W-1:0] coin_value;
    logic              coin_accept;
    logic              cafe_btn;
    logic              sopa_btn;
    logic              cancel_btn;
    logic              cafe_out;
    logic              sopa_out;
    logic              change_pulse;
    logic              insufficient;
    logic [CREDIT_W-1:0] credit;
    logic              busy;

    modport master (
        output coin_valid, coin_value,
        output cafe_btn, sopa_btn, cancel_btn,
        input  coin_accept, cafe_out, sopa_out,
        input  change_pulse, insufficient,
        input  credit, busy
    );

    modport slave (
        input  coin_valid, coin_value,
        input  cafe_btn, sopa_btn, cancel_btn,
        output coin_accept, cafe_out, sopa_out,
        output change_pulse, insufficient,
        output credit, busy
    );

endinterface

// File: rtl/vending_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared by the dispense length and change pulse spacing.
module vending_pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: coin credit, cafe/sopa selection, dispense timing, change.
// Define VENDING_TIMEOUT_EN to refund credit after TIMEOUT_CYCLES idle cycles.
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int CREDIT_W    = DEF_CREDIT_W,
    parameter int PRICE_CAFE  = DEF_PRICE_CAFE,
    parameter int PRICE_SOPA  = DEF_PRICE_SOPA,
    parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
    parameter int DISP_CYCLES = DEF_DISP_CYCLES
`ifdef VENDING_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    vending_ctrl_if.slave bus
);

    localparam int XW = CREDIT_W + 1;
    localparam int TW = cnt_w((DISP_CYCLES > 1) ? DISP_CYCLES - 1 : 1);

    localparam logic [XW-1:0]       MAX_X  = XW'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] P_CAFE = CREDIT_W'(PRICE_CAFE);
    localparam logic [CREDIT_W-1:0] P_SOPA = CREDIT_W'(PRICE_SOPA);
    localparam logic [TW-1:0]       T_DISP = TW'(DISP_CYCLES - 1);
    localparam logic [TW-1:0]       T_GAP  = TW'(1);

    state_t state, state_n;
    prod_t  prod, prod_n, sel;

    logic [CREDIT_W-1:0] credit, credit_n;
    logic [CREDIT_W-1:0] price, coin_ext;
    logic [XW-1:0]       sum;

    logic ins, ins_n;
    logic cafe_q, sopa_q, cancel_q;
    logic cafe_e, sopa_e, cancel_e;
    logic open_st, take;
    logic tload, tdone, to_expire;
    logic [TW-1:0] tval;

    assign cafe_e   = bus.cafe_btn & ~cafe_q;
    assign sopa_e   = bus.sopa_btn & ~sopa_q;
    assign cancel_e = bus.cancel_btn & ~cancel_q;

    assign open_st  = (state == ST_IDLE) || (state == ST_CREDIT);
    assign coin_ext = CREDIT_W'(bus.coin_value);
    assign sum      = {1'b0, credit} + XW'(bus.coin_value);

    assign bus.coin_accept = open_st
                          && (bus.coin_value != '0)
                          && (sum <= MAX_X);
    assign take = bus.coin_valid & bus.coin_accept;

    vending_pulse_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tload),
        .load_val (tval),
        .done     (tdone)
    );

`ifdef VENDING_TIMEOUT_EN
    localparam int OW = cnt_w(TIMEOUT_CYCLES);

    logic to_load, to_done;

    // Any activity, or being outside CREDIT, restarts the idle window.
    assign to_load = (state != ST_CREDIT) || take
                  || cafe_e || sopa_e || cancel_e;

    vending_pulse_timer #(.W(OW)) u_idle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (OW'(TIMEOUT_CYCLES - 1)),
        .done     (to_done)
    );

    assign to_expire = (state == ST_CREDIT) && !to_load && to_done;
`else
    assign to_expire = 1'b0;
`endif

    always_comb begin
        sel   = PROD_NONE;
        price = P_CAFE;
        if (sopa_e) begin
            sel   = PROD_SOPA;
            price = P_SOPA;
        end else if (cafe_e) begin
            sel   = PROD_CAFE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            prod     <= PROD_NONE;
            credit   <= '0;
            ins      <= 1'b0;
            cafe_q   <= 1'b0;
            sopa_q   <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state    <= state_n;
            prod     <= prod_n;
            credit   <= credit_n;
            ins      <= ins_n;
            cafe_q   <= bus.cafe_btn;
            sopa_q   <= bus.sopa_btn;
            cancel_q <= bus.cancel_btn;
        end
    end

    always_comb begin
        state_n  = state;
        prod_n   = prod;
        credit_n = credit;
        ins_n    = 1'b0;
        tload    = 1'b0;
        tval     = '0;
        unique case (state)
            ST_IDLE, ST_CREDIT: begin
                if (take) begin
                    credit_n = credit + coin_ext;
                end
                // Price is checked against credit held before this cycle's coin.
                if (cancel_e) begin
                    if (state == ST_CREDIT) begin
                        state_n = ST_CHANGE;
                        tload   = 1'b1;
                    end
                end else if (sel != PROD_NONE) begin
                    if (credit >= price) begin
                        credit_n = credit_n - price;
                        prod_n   = sel;
                        state_n  = ST_DISPENSE;
                        tload    = 1'b1;
                        tval     = T_DISP;
                    end else begin
                        ins_n = 1'b1;
                    end
                end else if (to_expire) begin
                    state_n = ST_CHANGE;
                    tload   = 1'b1;
                end
                if (state_n == ST_IDLE || state_n == ST_CREDIT) begin
                    state_n = (credit_n == '0) ? ST_IDLE : ST_CREDIT;
                end
            end
            ST_DISPENSE: begin
                if (tdone) begin
                    state_n = (credit != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (credit == '0) begin
                    state_n = ST_IDLE;
                end else if (tdone) begin
                    credit_n = credit - CREDIT_W'(1);
                    tload    = 1'b1;
                    tval     = T_GAP;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.cafe_out     = (state == ST_DISPENSE) && (prod == PROD_CAFE);
    assign bus.sopa_out     = (state == ST_DISPENSE) && (prod == PROD_SOPA);
    assign bus.change_pulse = (state == ST_CHANGE) && tdone && (credit != '0);
    assign bus.insufficient = ins;
    assign bus.credit       = credit;
    assign bus.busy         = (state == ST_DISPENSE) || (state == ST_CHANGE);

endmodule

// File: tb/tb_vending_ctrl.sv
// Scoreboard bench for vending_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares them as the controller raises outputs.
module tb_vending_ctrl;
    import vending_pkg::*;

    localparam int EV_CAFE = 1;
    localparam int EV_SOPA = 2;
    localparam int EV_CHG  = 3;
    localparam int EV_INS  = 4;

    typedef struct {
        int kind;
        int cr;
    } ev_s;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ev_s exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  mk;
    ev_s me;

    vending_ctrl_if #(.CREDIT_W(8)) vif ();

    vending_ctrl #(
        .CREDIT_W    (8),
        .PRICE_CAFE  (3),
        .PRICE_SOPA  (5),
        .MAX_CREDIT  (20),
        .DISP_CYCLES (4)
`ifdef VENDING_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (10)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mk = 0;
            if (vif.cafe_out || vif.sopa_out)
                chk("one product", int'(vif.cafe_out & vif.sopa_out), 0);
            if (vif.cafe_out)          mk = EV_CAFE;
            else if (vif.sopa_out)     mk = EV_SOPA;
            else if (vif.change_pulse) mk = EV_CHG;
            else if (vif.insufficient) mk = EV_INS;
            if (mk != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected event", mk, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("event kind", mk, me.kind);
                    chk("event credit", int'(vif.credit), me.cr);
                end
            end
        end
    end

    task automatic push(input int kind, input int cr, input int n);
        ev_s e;
        e.kind = kind;
        e.cr   = cr;
        repeat (n) exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input int val, input logic cf,
                         input logic sp, input logic cn, output logic acc);
        vif.coin_valid = cv;
        vif.coin_value = 4'(val);
        vif.cafe_btn   = cf;
        vif.sopa_btn   = sp;
        vif.cancel_btn = cn;
        @(negedge clk);
        acc = vif.coin_accept;
        @(posedge clk);
        #1;
        vif.coin_valid = 1'b0;
        vif.coin_value = '0;
        vif.cafe_btn   = 1'b0;
        vif.sopa_btn   = 1'b0;
        vif.cancel_btn = 1'b0;
    endtask

    task automatic coin(input int v, input int exp_acc, input string nm);
        logic a;
        drive(1'b1, v, 1'b0, 1'b0, 1'b0, a);
        chk(nm, int'(a), exp_acc);
    endtask

    task automatic press(input logic cf, input logic sp, input logic cn);
        logic a;
        drive(1'b0, 0, cf, sp, cn, a);
    endtask

    task automatic wait_busy(input string nm, input int exp_n);
        int n = 0;
        while (vif.busy && n < 200) begin
            tick();
            n++;
        end
        chk(nm, n, exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        vif.coin_valid = 1'b0;
        vif.coin_value = '0;
        vif.cafe_btn   = 1'b0;
        vif.sopa_btn   = 1'b0;
        vif.cancel_btn = 1'b0;

        tick();
        tick();
        chk("reset credit", int'(vif.credit), 0);
        chk("reset outputs", int'({vif.cafe_out, vif.sopa_out,
            vif.change_pulse, vif.insufficient, vif.busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: 2+1 then cafe at exact price
        coin(0, 0, "t1 coin0 refused");
        chk("t1 credit0", int'(vif.credit), 0);
        coin(2, 1, "t1 coin2");
        chk("t1 credit2", int'(vif.credit), 2);
        coin(1, 1, "t1 coin1");
        chk("t1 credit3", int'(vif.credit), 3);
        push(EV_CAFE, 0, 4);
        press(1'b1, 1'b0, 1'b0);
        chk("t1 credit after", int'(vif.credit), 0);
        wait_busy("t1 busy cycles", 4);

        // 2: both buttons select sopa, change of 2
        coin(5, 1, "t2 coin5");
        coin(2, 1, "t2 coin2");
        chk("t2 credit7", int'(vif.credit), 7);
        push(EV_SOPA, 2, 4);
        push(EV_CHG, 2, 1);
        push(EV_CHG, 1, 1);
        press(1'b1, 1'b1, 1'b0);
        chk("t2 credit2", int'(vif.credit), 2);
        wait_busy("t2 busy cycles", 8);
        chk("t2 credit end", int'(vif.credit), 0);

        // 3: insufficient sopa, then cancel refund
        coin(2, 1, "t3 coin2");
        push(EV_INS, 2, 1);
        press(1'b0, 1'b1, 1'b0);
        chk("t3 credit held", int'(vif.credit), 2);
        push(EV_CHG, 2, 1);
        push(EV_CHG, 1, 1);
        press(1'b0, 1'b0, 1'b1);
        wait_busy("t3 change cycles", 4);
        chk("t3 credit end", int'(vif.credit), 0);

        // price checked before same-cycle coin
        coin(2, 1, "pc coin2");
        push(EV_INS, 3, 1);
        drive(1'b1, 1, 1'b1, 1'b0, 1'b0, a);
        chk("pc coin accepted", int'(a), 1);
        chk("pc credit3", int'(vif.credit), 3);
        tick();
        push(EV_CAFE, 0, 4);
        press(1'b1, 1'b0, 1'b0);
        wait_busy("pc busy cycles", 4);
        chk("pc credit end", int'(vif.credit), 0);

        // empty-credit select and cancel in IDLE
        push(EV_INS, 0, 1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("idle cancel busy", int'(vif.busy), 0);
        chk("idle cancel credit", int'(vif.credit), 0);

        // 4: credit ceiling
        coin(9, 1, "t4 coin9a");
        coin(9, 1, "t4 coin9b");
        chk("t4 credit18", int'(vif.credit), 18);
        coin(5, 0, "t4 coin5 refused");
        chk("t4 credit still18", int'(vif.credit), 18);
        coin(2, 1, "t4 coin2");
        chk("t4 credit20", int'(vif.credit), 20);
        coin(1, 0, "t4 coin1 over max");
        for (int i = 20; i >= 1; i--) push(EV_CHG, i, 1);
        press(1'b0, 1'b0, 1'b1);
        coin(1, 0, "t4 coin in change");
        wait_busy("t4 change cycles", 39);
        chk("t4 credit end", int'(vif.credit), 0);

        // 5: reset mid-dispense
        coin(5, 1, "t5 coin5");
        push(EV_CAFE, 2, 2);
        press(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5 outputs in reset", int'({vif.cafe_out, vif.sopa_out,
            vif.change_pulse, vif.busy}), 0);
        chk("t5 credit in reset", int'(vif.credit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5 busy after", int'(vif.busy), 0);
        chk("t5 credit after", int'(vif.credit), 0);

`ifdef VENDING_TIMEOUT_EN
        // 6: idle auto-refund
        begin
            int n = 0;
            push(EV_CHG, 3, 1);
            push(EV_CHG, 2, 1);
            push(EV_CHG, 1, 1);
            coin(3, 1, "t6 coin3");
            while (!vif.busy && n < 50) begin
                tick();
                n++;
            end
            chk("t6 idle cycles", n, 10);
            wait_busy("t6 change cycles", 6);
            chk("t6 credit end", int'(vif.credit), 0);
        end
`endif

        tick();
        tick();
        tick();
        chk("queue drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
